// File: rtl/ddr_wr_burst_packer_pkg.sv
// Shared configuration for the DDR write burst packer: geometry defaults and FSM state encoding.
package ddr_wr_burst_packer_pkg;

    localparam int DEF_BA_BITS   = 2;
    localparam int DEF_ROW_BITS  = 13;
    localparam int DEF_COL_BITS  = 11;
    localparam int DEF_DQ_LEVEL  = 1;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_TIMEOUT   = 64;
    localparam int DEF_DW        = 8 << DEF_DQ_LEVEL;
    localparam int DEF_AW        = DEF_BA_BITS + DEF_ROW_BITS + DEF_COL_BITS + DEF_DQ_LEVEL - 1;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_AW      = 2'd1,
        S_W       = 2'd2,
        S_B       = 2'd3
    } state_e;

endpackage

// File: rtl/ddr_wr_burst_packer_if.sv
// Packer boundary: user single-word write stream plus AXI aw/w/b channels toward the controller.
interface ddr_wr_burst_packer_if
    import ddr_wr_burst_packer_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          s_flush;

    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid;
    logic          wready;
    logic          wlast;
    logic [DW-1:0] wdata;
    logic          bvalid;
    logic          bready;

    // slave = the packer; master = its environment (user logic and controller)
    modport slave (
        input  s_valid, s_addr, s_data, s_flush, awready, wready, bvalid,
        output s_ready, awvalid, awaddr, awlen, wvalid, wlast, wdata, bready
    );
    modport master (
        output s_valid, s_addr, s_data, s_flush, awready, wready, bvalid,
        input  s_ready, awvalid, awaddr, awlen, wvalid, wlast, wdata, bready
    );

endinterface

// File: rtl/ddr_wr_fifo.sv
// Synchronous FIFO holding the data beats of the burst being collected; head is visible without a read cycle.
module ddr_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, wr_d, rd_q, rd_d;

    // extra pointer MSB separates full from empty when the low bits match
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign dout  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push && !full) wr_d = wr_q + 1'b1;
        if (pop && !empty) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/ddr_wr_burst_packer.sv
// Coalesces address-contiguous single-word writes into AXI bursts for ddr_sdram_ctrl.
// Optional idle-timeout burst close is built when DDR_WR_TIMEOUT_EN is defined.
module ddr_wr_burst_packer
    import ddr_wr_burst_packer_pkg::*;
#(
    parameter int BA_BITS   = DEF_BA_BITS,
    parameter int ROW_BITS  = DEF_ROW_BITS,
    parameter int COL_BITS  = DEF_COL_BITS,
    parameter int DQ_LEVEL  = DEF_DQ_LEVEL,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                   core_clk,
    input  logic                   core_clk_rstn,
    ddr_wr_burst_packer_if.slave   bus,
    output logic                   wr_done
);
    localparam int DW = 8 << DQ_LEVEL;
    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1;
    localparam int RW = COL_BITS + DQ_LEVEL - 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    if (((MAX_BURST & (MAX_BURST - 1)) != 0) || (MAX_BURST > 256) || (TIMEOUT < 1)) begin : g_bad_params
        $error("ddr_wr_burst_packer: MAX_BURST must be a power of 2 <= 256 and TIMEOUT >= 1");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d, beat_q, beat_d;
    logic [AW-1:0] start_q, start_d, next_q, next_d;
    logic          awvalid_q, awvalid_d, bready_q, bready_d, wr_done_q, wr_done_d;
    logic          contig, accept, pop, close, fifo_full, fifo_empty;
    logic [AW-1:0] acc_next;
    logic [DW-1:0] fifo_head;

`ifdef DDR_WR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          timeout_hit;

    assign timeout_hit = (count_q != '0) && (idle_q == TW'(TIMEOUT - 1));
    assign idle_d = (state_q != S_COLLECT || accept || count_q == '0) ? '0 : idle_q + 1'b1;

    always_ff @(posedge core_clk or negedge core_clk_rstn) begin
        if (!core_clk_rstn) idle_q <= '0;
        else                idle_q <= idle_d;
    end
`endif

    assign contig      = (count_q == '0) || (bus.s_addr == next_q);
    assign bus.s_ready = core_clk_rstn && (state_q == S_COLLECT) && contig && !fifo_full;
    assign accept      = bus.s_valid && bus.s_ready;
    assign acc_next    = bus.s_addr + AW'(1);

    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = start_q;
    assign bus.awlen   = 8'(count_q - CW'(1));
    assign bus.wvalid  = (state_q == S_W) && !fifo_empty;
    assign bus.wdata   = fifo_head;
    assign bus.wlast   = bus.wvalid && (beat_q == count_q - CW'(1));
    assign bus.bready  = bready_q;
    assign wr_done     = wr_done_q;
    assign pop         = bus.wvalid && bus.wready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        beat_d    = beat_q;
        start_d   = start_q;
        next_d    = next_q;
        awvalid_d = awvalid_q;
        bready_d  = bready_q;
        wr_done_d = 1'b0;
        close     = 1'b0;
        unique case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    count_d = count_q + CW'(1);
                    next_d  = acc_next;
                    if (count_q == '0) start_d = bus.s_addr;
                    // all close reasons merge into one flag, so coincident ones give one burst
                    if (count_q == CW'(MAX_BURST - 1) || bus.s_flush || acc_next[RW-1:0] == '0)
                        close = 1'b1;
                end else if (bus.s_valid && !contig) begin
                    close = 1'b1;
`ifdef DDR_WR_TIMEOUT_EN
                end else if (timeout_hit) begin
                    close = 1'b1;
`endif
                end
                if (close) begin
                    state_d   = S_AW;
                    awvalid_d = 1'b1;
                end
            end
            S_AW: begin
                if (bus.awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (pop) begin
                    beat_d = beat_q + CW'(1);
                    if (bus.wlast) begin
                        bready_d = 1'b1;
                        state_d  = S_B;
                    end
                end
            end
            S_B: begin
                if (bus.bvalid) begin
                    bready_d  = 1'b0;
                    wr_done_d = 1'b1;
                    count_d   = '0;
                    state_d   = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_clk_rstn) begin
        if (!core_clk_rstn) begin
            state_q   <= S_COLLECT;
            count_q   <= '0;
            beat_q    <= '0;
            start_q   <= '0;
            next_q    <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            beat_q    <= beat_d;
            start_q   <= start_d;
            next_q    <= next_d;
            awvalid_q <= awvalid_d;
            bready_q  <= bready_d;
            wr_done_q <= wr_done_d;
        end
    end

    ddr_wr_fifo #(
        .DEPTH (MAX_BURST),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (core_clk),
        .rst_n (core_clk_rstn),
        .push  (accept),
        .din   (bus.s_data),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
